fetch_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register of the five-stage MIPS pipeline. It holds the program counter, selects the next PC, and registers the fetched word. It supplies `opD`/`funcD` straight to the decode-stage control unit. It also detects the halt word and drains the pipeline before asserting `halted`.

---
 rtl/fetch_stage.sv | 90 +++++++++
 tb/tb_fetch_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC and next-PC select, IF/ID register, halt-word drain (FETCH_PERF_CNT_EN adds cycle_count/instr_count)
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic StallF,
  input  logic StallD,
  input  logic FlushD,
  input  logic PCSrcD,
  input  logic [31:0] PCBranchD,
  input  logic JumpD,
  input  logic JrD,
  input  logic [31:0] RegJrD,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [5:0] opD,
  output logic [5:0] funcD,
  output logic [31:0] PCPlus4D,
  output logic validD,
`ifdef FETCH_PERF_CNT_EN
  output logic halted,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`else
  output logic halted
`endif
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [31:0] pc_plus4, target;
  logic redirect, halt_det, load_en;
  always_comb begin
    pc_plus4 = PCF + 32'd4;
    redirect = JrD | JumpD | PCSrcD;
    target = JrD ? RegJrD : JumpD ? {PCPlus4D[31:28], InstrD[25:0], 2'b00} : PCBranchD;
    halt_det = state == RUN && imem_rdata == HALT_WORD && !StallF && !StallD && !FlushD && !redirect;
    load_en = state == RUN && !StallD && !FlushD && !redirect && !halt_det;
  end
  assign imem_addr = PCF;
  assign opD = InstrD[31:26];
  assign funcD = InstrD[5:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt <= '0;
      PCF <= RESET_PC;
      InstrD <= '0;
      PCPlus4D <= '0;
      validD <= 1'b0;
      halted <= 1'b0;
    end else begin
      if (state == RUN && !StallF && !halt_det) PCF <= redirect ? target : pc_plus4;
      if (load_en) begin
        InstrD <= imem_rdata;
        PCPlus4D <= pc_plus4;
        validD <= 1'b1;
      end else if (state != RUN || !StallD) begin
        InstrD <= '0;
        PCPlus4D <= '0;
        validD <= 1'b0;
      end
      if (halt_det) begin
        state <= DRAIN;
        cnt <= 4'(DRAIN_CYCLES - 1);
      end else if (state == DRAIN) begin
        if (cnt == 4'd0) begin
          state <= HALTED;
          halted <= 1'b1;
        end else cnt <= cnt - 4'd1;
      end
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (state != HALTED) cycle_count <= cycle_count + 32'd1;
      if (load_en) instr_count <= instr_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table, scoreboard run and halt sequence for fetch_stage
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] imem_addr, imem_rdata;
  logic StallF, StallD, FlushD, PCSrcD, JumpD, JrD;
  logic [31:0] PCBranchD, RegJrD;
  logic [31:0] PCF, InstrD, PCPlus4D;
  logic [5:0] opD, funcD;
  logic validD, halted;
  logic [31:0] mem [128];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  assign imem_rdata = mem[imem_addr[8:2]];

  fetch_stage dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .PCSrcD(PCSrcD),
    .PCBranchD(PCBranchD), .JumpD(JumpD), .JrD(JrD), .RegJrD(RegJrD),
    .PCF(PCF), .InstrD(InstrD), .opD(opD), .funcD(funcD), .PCPlus4D(PCPlus4D),
    .validD(validD), .halted(halted)
  );

  typedef struct {
    logic sf, sd, fd, br, jmp, jr;
    logic [31:0] tgt, rj, pcf, instr, pc4;
    logic v;
  } vec_t;
  vec_t tv[17];

  typedef struct {
    logic [31:0] instr, pc4;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sf, sd, fd, br, jmp, jr, input logic [31:0] tgt, rj);
    StallF = sf; StallD = sd; FlushD = fd; PCSrcD = br; JumpD = jmp; JrD = jr;
    PCBranchD = tgt; RegJrD = rj;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    tick;
    reset = 1'b0;
  endtask

  initial begin
    exp_t e;
    logic [31:0] pc_m;
    logic [31:0] w;
    logic st;
    for (int i = 0; i < 128; i++) mem[i] = 32'h2400_0000 + i;
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;
    mem[3] = 32'h0800_0010;

    tv[0]  = '{0,0,0,0,0,0, 32'h0,   32'h0,   32'h4,   32'h2008_0005, 32'h4,   1'b1};
    tv[1]  = '{0,0,0,0,0,0, 32'h0,   32'h0,   32'h8,   32'h2009_0003, 32'h8,   1'b1};
    tv[2]  = '{0,0,0,1,0,0, 32'h40,  32'h0,   32'h40,  32'h0,         32'h0,   1'b0};
    tv[3]  = '{0,0,0,0,0,0, 32'h0,   32'h0,   32'h44,  32'h2400_0010, 32'h44,  1'b1};
    tv[4]  = '{0,0,0,1,1,1, 32'h40,  32'h100, 32'h100, 32'h0,         32'h0,   1'b0};
    tv[5]  = '{0,0,0,0,0,0, 32'h0,   32'h0,   32'h104, 32'h2400_0040, 32'h104, 1'b1};
    tv[6]  = '{1,1,0,0,0,0, 32'h0,   32'h0,   32'h104, 32'h2400_0040, 32'h104, 1'b1};
    tv[7]  = '{1,1,0,0,0,0, 32'h0,   32'h0,   32'h104, 32'h2400_0040, 32'h104, 1'b1};
    tv[8]  = '{1,1,1,0,0,0, 32'h0,   32'h0,   32'h104, 32'h2400_0040, 32'h104, 1'b1};
    tv[9]  = '{0,0,0,0,0,0, 32'h0,   32'h0,   32'h108, 32'h2400_0041, 32'h108, 1'b1};
    tv[10] = '{0,0,1,0,0,0, 32'h0,   32'h0,   32'h10C, 32'h0,         32'h0,   1'b0};
    tv[11] = '{0,0,0,0,0,0, 32'h0,   32'h0,   32'h110, 32'h2400_0043, 32'h110, 1'b1};
    tv[12] = '{0,0,0,0,0,1, 32'h0,   32'h8,   32'h8,   32'h0,         32'h0,   1'b0};
    tv[13] = '{0,0,0,0,0,0, 32'h0,   32'h0,   32'hC,   32'h2400_0002, 32'hC,   1'b1};
    tv[14] = '{0,0,0,0,0,0, 32'h0,   32'h0,   32'h10,  32'h0800_0010, 32'h10,  1'b1};
    tv[15] = '{0,0,0,0,1,0, 32'h0,   32'h0,   32'h40,  32'h0,         32'h0,   1'b0};
    tv[16] = '{0,0,0,0,0,0, 32'h0,   32'h0,   32'h44,  32'h2400_0010, 32'h44,  1'b1};

    do_reset;
    chk("reset_pcf", PCF, 32'h0);
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_instr", InstrD, 32'h0);
    chk("reset_op_func", {20'h0, opD, funcD}, 32'h0);
    chk("reset_pc4", PCPlus4D, 32'h0);
    chk("reset_valid_halted", {30'h0, validD, halted}, 32'h0);

    for (int i = 0; i < 17; i++) begin
      drive(tv[i].sf, tv[i].sd, tv[i].fd, tv[i].br, tv[i].jmp, tv[i].jr, tv[i].tgt, tv[i].rj);
      tick;
      w = tv[i].instr;
      chk($sformatf("v%0d_pcf", i), PCF, tv[i].pcf);
      chk($sformatf("v%0d_instr", i), InstrD, w);
      chk($sformatf("v%0d_op", i), {26'h0, opD}, {26'h0, w[31:26]});
      chk($sformatf("v%0d_func", i), {26'h0, funcD}, {26'h0, w[5:0]});
      chk($sformatf("v%0d_pc4", i), PCPlus4D, tv[i].pc4);
      chk($sformatf("v%0d_valid", i), {31'h0, validD}, {31'h0, tv[i].v});
    end

    do_reset;
    pc_m = 32'h0;
    for (int c = 0; c < 24; c++) begin
      st = ($urandom_range(0, 3) == 0);
      drive(st, st, 0, 0, 0, 0, 0, 0);
      if (!st) begin
        e.instr = mem[pc_m[8:2]];
        e.pc4 = pc_m + 32'd4;
        sb.push_back(e);
        pc_m = pc_m + 32'd4;
      end
      tick;
      chk("sb_pcf", PCF, pc_m);
      if (!st) begin
        if (sb.size() == 0) chk("sb_underflow", 32'h1, 32'h0);
        else begin
          e = sb.pop_front();
          chk("sb_valid", {31'h0, validD}, 32'h1);
          chk("sb_instr", InstrD, e.instr);
          chk("sb_pc4", PCPlus4D, e.pc4);
        end
      end
    end
    chk("sb_empty", sb.size(), 32'h0);

    mem[3] = 32'hFFFF_FFFF;
    do_reset;
    for (int c = 0; c < 3; c++) tick;
    chk("h_pcf_at_halt", PCF, 32'hC);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      tick;
      chk("h_stall_pcf", PCF, 32'hC);
      chk("h_stall_instr", InstrD, 32'h2400_0002);
      chk("h_stall_halted", {31'h0, halted}, 32'h0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("h_detect_pcf", PCF, 32'hC);
    chk("h_detect_valid", {31'h0, validD}, 32'h0);
    chk("h_detect_instr", InstrD, 32'h0);
    chk("h_detect_halted", {31'h0, halted}, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      if (k == 5) drive(0, 0, 0, 0, 0, 1, 0, 32'h100);
      tick;
      chk($sformatf("h_drain%0d_halted", k), {31'h0, halted}, {31'h0, k >= 4});
      chk($sformatf("h_drain%0d_valid", k), {31'h0, validD}, 32'h0);
      chk($sformatf("h_drain%0d_pcf", k), PCF, 32'hC);
    end
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("h_reset_pcf", PCF, 32'h0);
    chk("h_reset_halted", {31'h0, halted}, 32'h0);
    reset = 1'b0;
    tick;
    chk("h_rerun_pcf", PCF, 32'h4);
    chk("h_rerun_instr", InstrD, 32'h2008_0005);
    chk("h_rerun_valid", {31'h0, validD}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
